axil_cmd_master: RTL and testbench

- AXI4-Lite master. Converts single-cycle command pulses from local logic into one AXI4-Lite write or read transaction.
- Drives the slave side of register blocks in the design, e.g. the LED register slave and other ASHI-based peripherals.
- Write and read engines are independent and may run concurrently.
- Each engine reports completion through an idle flag and a captured response code.

---
 rtl/axil_cmd_master.sv | 207 ++++++++++++++++++++
 tb/tb_axil_cmd_master.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_cmd_master.sv
// AXI4-Lite master: turns single-cycle write/read command pulses into one
// AXI4-Lite transaction each, with independent write and read engines.
module axil_cmd_master #(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          resetn,

  input  logic [AW-1:0] cmd_waddr,
  input  logic [31:0]   cmd_wdata,
  input  logic          cmd_write,
  output logic [1:0]    cmd_wresp,
  output logic          cmd_widle,

  input  logic [AW-1:0] cmd_raddr,
  input  logic          cmd_read,
  output logic [31:0]   cmd_rdata,
  output logic [1:0]    cmd_rresp,
  output logic          cmd_ridle,

  output logic [AW-1:0] M_AXI_AWADDR,
  output logic          M_AXI_AWVALID,
  output logic [2:0]    M_AXI_AWPROT,
  input  logic          M_AXI_AWREADY,

  output logic [31:0]   M_AXI_WDATA,
  output logic [3:0]    M_AXI_WSTRB,
  output logic          M_AXI_WVALID,
  input  logic          M_AXI_WREADY,

  input  logic [1:0]    M_AXI_BRESP,
  input  logic          M_AXI_BVALID,
  output logic          M_AXI_BREADY,

  output logic [AW-1:0] M_AXI_ARADDR,
  output logic          M_AXI_ARVALID,
  output logic [2:0]    M_AXI_ARPROT,
  input  logic          M_AXI_ARREADY,

  input  logic [31:0]   M_AXI_RDATA,
  input  logic [1:0]    M_AXI_RRESP,
  input  logic          M_AXI_RVALID,
  output logic          M_AXI_RREADY
);

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rstate_t;

  // ---------------- write engine ----------------
  wstate_t       wstate_reg, wstate_next;
  logic [AW-1:0] awaddr_reg, awaddr_next;
  logic [31:0]   wdata_reg, wdata_next;
  logic          awvalid_reg, awvalid_next;
  logic          wvalid_reg, wvalid_next;
  logic          bready_reg, bready_next;
  logic [1:0]    wresp_reg, wresp_next;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wstate_reg  <= W_IDLE;
      awaddr_reg  <= '0;
      wdata_reg   <= '0;
      awvalid_reg <= 1'b0;
      wvalid_reg  <= 1'b0;
      bready_reg  <= 1'b0;
      wresp_reg   <= 2'b00;
    end else begin
      wstate_reg  <= wstate_next;
      awaddr_reg  <= awaddr_next;
      wdata_reg   <= wdata_next;
      awvalid_reg <= awvalid_next;
      wvalid_reg  <= wvalid_next;
      bready_reg  <= bready_next;
      wresp_reg   <= wresp_next;
    end
  end

  always_comb begin
    wstate_next  = wstate_reg;
    awaddr_next  = awaddr_reg;
    wdata_next   = wdata_reg;
    awvalid_next = awvalid_reg;
    wvalid_next  = wvalid_reg;
    bready_next  = bready_reg;
    wresp_next   = wresp_reg;
    case (wstate_reg)
      W_IDLE: begin
        if (cmd_write) begin
          awaddr_next  = cmd_waddr;
          wdata_next   = cmd_wdata;
          awvalid_next = 1'b1;
          wvalid_next  = 1'b1;
          wstate_next  = W_ADDR;
        end
      end
      W_ADDR: begin
        // Each channel drops its VALID independently after its own handshake;
        // the response phase starts once neither VALID remains pending.
        awvalid_next = awvalid_reg && !M_AXI_AWREADY;
        wvalid_next  = wvalid_reg && !M_AXI_WREADY;
        if (!awvalid_next && !wvalid_next) begin
          bready_next = 1'b1;
          wstate_next = W_RESP;
        end
      end
      W_RESP: begin
        if (M_AXI_BVALID && bready_reg) begin
          wresp_next  = M_AXI_BRESP;
          bready_next = 1'b0;
          wstate_next = W_IDLE;
        end
      end
      default: begin
        awvalid_next = 1'b0;
        wvalid_next  = 1'b0;
        bready_next  = 1'b0;
        wstate_next  = W_IDLE;
      end
    endcase
  end

  // ---------------- read engine ----------------
  rstate_t       rstate_reg, rstate_next;
  logic [AW-1:0] araddr_reg, araddr_next;
  logic          arvalid_reg, arvalid_next;
  logic          rready_reg, rready_next;
  logic [31:0]   rdata_reg, rdata_next;
  logic [1:0]    rresp_reg, rresp_next;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rstate_reg  <= R_IDLE;
      araddr_reg  <= '0;
      arvalid_reg <= 1'b0;
      rready_reg  <= 1'b0;
      rdata_reg   <= '0;
      rresp_reg   <= 2'b00;
    end else begin
      rstate_reg  <= rstate_next;
      araddr_reg  <= araddr_next;
      arvalid_reg <= arvalid_next;
      rready_reg  <= rready_next;
      rdata_reg   <= rdata_next;
      rresp_reg   <= rresp_next;
    end
  end

  always_comb begin
    rstate_next  = rstate_reg;
    araddr_next  = araddr_reg;
    arvalid_next = arvalid_reg;
    rready_next  = rready_reg;
    rdata_next   = rdata_reg;
    rresp_next   = rresp_reg;
    case (rstate_reg)
      R_IDLE: begin
        if (cmd_read) begin
          araddr_next  = cmd_raddr;
          arvalid_next = 1'b1;
          rstate_next  = R_ADDR;
        end
      end
      R_ADDR: begin
        if (arvalid_reg && M_AXI_ARREADY) begin
          arvalid_next = 1'b0;
          rready_next  = 1'b1;
          rstate_next  = R_DATA;
        end
      end
      R_DATA: begin
        if (M_AXI_RVALID && rready_reg) begin
          rdata_next  = M_AXI_RDATA;
          rresp_next  = M_AXI_RRESP;
          rready_next = 1'b0;
          rstate_next = R_IDLE;
        end
      end
      default: begin
        arvalid_next = 1'b0;
        rready_next  = 1'b0;
        rstate_next  = R_IDLE;
      end
    endcase
  end

  // ---------------- outputs ----------------
  // Idle flags fall in the same cycle as the start pulse so local logic never
  // sees a one-cycle window where a just-issued command looks finished.
  assign cmd_widle = (wstate_reg == W_IDLE) && !cmd_write;
  assign cmd_ridle = (rstate_reg == R_IDLE) && !cmd_read;
  assign cmd_wresp = wresp_reg;
  assign cmd_rdata = rdata_reg;
  assign cmd_rresp = rresp_reg;

  assign M_AXI_AWADDR  = awaddr_reg;
  assign M_AXI_AWVALID = awvalid_reg;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_WDATA   = wdata_reg;
  assign M_AXI_WSTRB   = 4'hF;
  assign M_AXI_WVALID  = wvalid_reg;
  assign M_AXI_BREADY  = bready_reg;
  assign M_AXI_ARADDR  = araddr_reg;
  assign M_AXI_ARVALID = arvalid_reg;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_RREADY  = rready_reg;

endmodule

// File: tb/tb_axil_cmd_master.sv
// Self-checking bench for axil_cmd_master: directed scenarios plus randomized
// commands and slave latencies, checked every cycle against a transaction-level model.
module tb_axil_cmd_master;
  localparam int AW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          resetn;
  logic [AW-1:0] cmd_waddr, cmd_raddr;
  logic [31:0]   cmd_wdata;
  logic          cmd_write, cmd_read;
  logic [1:0]    cmd_wresp, cmd_rresp;
  logic [31:0]   cmd_rdata;
  logic          cmd_widle, cmd_ridle;
  logic [AW-1:0] M_AXI_AWADDR, M_AXI_ARADDR;
  logic          M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
  logic [2:0]    M_AXI_AWPROT, M_AXI_ARPROT;
  logic [31:0]   M_AXI_WDATA, M_AXI_RDATA;
  logic [3:0]    M_AXI_WSTRB;
  logic [1:0]    M_AXI_BRESP, M_AXI_RRESP;
  logic          M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
  logic          M_AXI_RVALID, M_AXI_RREADY;

  axil_cmd_master #(.AW(AW)) dut (
    .clk(clk), .resetn(resetn),
    .cmd_waddr(cmd_waddr), .cmd_wdata(cmd_wdata), .cmd_write(cmd_write),
    .cmd_wresp(cmd_wresp), .cmd_widle(cmd_widle),
    .cmd_raddr(cmd_raddr), .cmd_read(cmd_read), .cmd_rdata(cmd_rdata),
    .cmd_rresp(cmd_rresp), .cmd_ridle(cmd_ridle),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID),
    .M_AXI_AWPROT(M_AXI_AWPROT), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARVALID(M_AXI_ARVALID),
    .M_AXI_ARPROT(M_AXI_ARPROT), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: one outstanding command per engine, tracked by
  // which handshakes of that command have happened so far.
  bit          m_wbusy, m_aw_done, m_w_done, m_rbusy, m_ar_done;
  logic [31:0] m_waddr, m_wdata, m_raddr, m_rdata;
  logic [1:0]  m_wresp, m_rresp;
  int          m_wacc, m_racc;

  // Slave behaviour: READY after *_lat cycles of VALID, response after *_lat
  // cycles of the master being ready for it.
  int          aw_lat, w_lat, b_lat, ar_lat, r_lat;
  int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  bit          rand_mode;
  logic [1:0]  dir_bresp, dir_rresp, s_bresp, s_rresp;
  logic [31:0] dir_rdata, s_rdata;

  // Handshake counters observed directly on the bus.
  int          n_aw, n_w, n_b, n_ar, n_r;
  logic [31:0] last_awaddr, last_wdata;
  always @(posedge clk) begin
    if (resetn) begin
      if (M_AXI_AWVALID && M_AXI_AWREADY) begin
        n_aw <= n_aw + 1;
        last_awaddr <= M_AXI_AWADDR;
      end
      if (M_AXI_WVALID && M_AXI_WREADY) begin
        n_w <= n_w + 1;
        last_wdata <= M_AXI_WDATA;
      end
      if (M_AXI_BVALID && M_AXI_BREADY) n_b <= n_b + 1;
      if (M_AXI_ARVALID && M_AXI_ARREADY) n_ar <= n_ar + 1;
      if (M_AXI_RVALID && M_AXI_RREADY) n_r <= n_r + 1;
    end
  end

  task automatic randomize_lat();
    aw_lat = $urandom_range(0, 4);
    w_lat  = $urandom_range(0, 4);
    b_lat  = $urandom_range(0, 3);
    ar_lat = $urandom_range(0, 4);
    r_lat  = $urandom_range(0, 3);
  endtask

  // One clock cycle: compare outputs with the model, drive the slave, advance the model.
  task automatic step();
    bit e_awv, e_wv, e_br, e_arv, e_rr;
    bit aw_hs, w_hs, b_hs, ar_hs, r_hs;
    @(negedge clk);
    e_awv = m_wbusy && !m_aw_done;
    e_wv  = m_wbusy && !m_w_done;
    e_br  = m_wbusy && m_aw_done && m_w_done;
    e_arv = m_rbusy && !m_ar_done;
    e_rr  = m_rbusy && m_ar_done;
    chk("awvalid", M_AXI_AWVALID, e_awv);
    chk("wvalid", M_AXI_WVALID, e_wv);
    chk("bready", M_AXI_BREADY, e_br);
    chk("arvalid", M_AXI_ARVALID, e_arv);
    chk("rready", M_AXI_RREADY, e_rr);
    if (e_awv) chk("awaddr", M_AXI_AWADDR, m_waddr);
    if (e_wv) chk("wdata", M_AXI_WDATA, m_wdata);
    if (e_arv) chk("araddr", M_AXI_ARADDR, m_raddr);
    chk("wstrb", M_AXI_WSTRB, 4'hF);
    chk("prot", {M_AXI_AWPROT, M_AXI_ARPROT}, 6'd0);
    chk("cmd_wresp", cmd_wresp, m_wresp);
    chk("cmd_rdata", cmd_rdata, m_rdata);
    chk("cmd_rresp", cmd_rresp, m_rresp);

    M_AXI_AWREADY = (aw_cnt >= aw_lat);
    M_AXI_WREADY  = (w_cnt >= w_lat);
    M_AXI_BVALID  = e_br && (b_cnt >= b_lat);
    M_AXI_BRESP   = M_AXI_BVALID ? s_bresp : 2'b00;
    M_AXI_ARREADY = (ar_cnt >= ar_lat);
    M_AXI_RVALID  = e_rr && (r_cnt >= r_lat);
    M_AXI_RDATA   = M_AXI_RVALID ? s_rdata : 32'h0;
    M_AXI_RRESP   = M_AXI_RVALID ? s_rresp : 2'b00;
    #1;
    chk("cmd_widle", cmd_widle, !m_wbusy && !cmd_write);
    chk("cmd_ridle", cmd_ridle, !m_rbusy && !cmd_read);

    if (!resetn) begin
      m_wbusy = 0; m_aw_done = 0; m_w_done = 0; m_rbusy = 0; m_ar_done = 0;
      m_wresp = 2'b00; m_rdata = 32'h0; m_rresp = 2'b00;
      aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
    end else begin
      if (m_wbusy) begin
        aw_hs = e_awv && M_AXI_AWREADY;
        w_hs  = e_wv && M_AXI_WREADY;
        b_hs  = e_br && M_AXI_BVALID;
        aw_cnt = (e_awv && !aw_hs) ? aw_cnt + 1 : 0;
        w_cnt  = (e_wv && !w_hs) ? w_cnt + 1 : 0;
        b_cnt  = (e_br && !b_hs) ? b_cnt + 1 : 0;
        if (aw_hs) m_aw_done = 1;
        if (w_hs) m_w_done = 1;
        if (b_hs) begin
          m_wresp = s_bresp;
          m_wbusy = 0;
        end else if (!e_br && m_aw_done && m_w_done) begin
          s_bresp = rand_mode ? 2'($urandom_range(0, 3)) : dir_bresp;
        end
      end else if (cmd_write) begin
        m_wbusy = 1; m_aw_done = 0; m_w_done = 0;
        m_waddr = cmd_waddr; m_wdata = cmd_wdata; m_wacc++;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        if (rand_mode) randomize_lat();
      end
      if (m_rbusy) begin
        ar_hs = e_arv && M_AXI_ARREADY;
        r_hs  = e_rr && M_AXI_RVALID;
        ar_cnt = (e_arv && !ar_hs) ? ar_cnt + 1 : 0;
        r_cnt  = (e_rr && !r_hs) ? r_cnt + 1 : 0;
        if (ar_hs) begin
          m_ar_done = 1;
          s_rdata = rand_mode ? 32'($urandom) : dir_rdata;
          s_rresp = rand_mode ? 2'($urandom_range(0, 3)) : dir_rresp;
        end
        if (r_hs) begin
          m_rdata = s_rdata; m_rresp = s_rresp; m_rbusy = 0;
        end
      end else if (cmd_read) begin
        m_rbusy = 1; m_ar_done = 0; m_raddr = cmd_raddr; m_racc++;
        ar_cnt = 0; r_cnt = 0;
        if (rand_mode) randomize_lat();
      end
    end
    @(posedge clk);
    #1;
    cmd_write = 1'b0;
    cmd_read  = 1'b0;
  endtask

  task automatic wait_widle(input int max, input string name);
    int n = 0;
    while (!cmd_widle && n < max) begin step(); n++; end
    chk(name, cmd_widle, 1'b1);
  endtask

  task automatic wait_ridle(input int max, input string name);
    int n = 0;
    while (!cmd_ridle && n < max) begin step(); n++; end
    chk(name, cmd_ridle, 1'b1);
  endtask

  task automatic set_lat(input int a, input int w, input int b, input int ar, input int r);
    aw_lat = a; w_lat = w; b_lat = b; ar_lat = ar; r_lat = r;
  endtask

  int aw0, w0, b0, ar0, r0;

  initial begin
    resetn = 1'b0; cmd_write = 0; cmd_read = 0;
    cmd_waddr = '0; cmd_wdata = '0; cmd_raddr = '0;
    M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0; M_AXI_BRESP = 0;
    M_AXI_ARREADY = 0; M_AXI_RVALID = 0; M_AXI_RDATA = 0; M_AXI_RRESP = 0;
    m_wbusy = 0; m_aw_done = 0; m_w_done = 0; m_rbusy = 0; m_ar_done = 0;
    m_waddr = 0; m_wdata = 0; m_raddr = 0; m_rdata = 0; m_wresp = 0; m_rresp = 0;
    m_wacc = 0; m_racc = 0;
    n_aw = 0; n_w = 0; n_b = 0; n_ar = 0; n_r = 0;
    last_awaddr = 0; last_wdata = 0;
    rand_mode = 0; dir_bresp = 0; dir_rresp = 0; dir_rdata = 0; s_bresp = 0; s_rresp = 0; s_rdata = 0;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
    set_lat(0, 0, 0, 0, 0);
    repeat (3) step();
    resetn = 1'b1;
    step();
    chk("reset_awaddr", M_AXI_AWADDR, 32'h0);
    chk("reset_wdata", M_AXI_WDATA, 32'h0);
    chk("reset_araddr", M_AXI_ARADDR, 32'h0);
    chk("reset_rdata", cmd_rdata, 32'h0);

    // Zero-wait write: VALIDs in cycle 1, BREADY in cycle 2, idle in cycle 3.
    aw0 = n_aw;
    cmd_waddr = 32'h0; cmd_wdata = 32'h0000A5A5; cmd_write = 1;
    step();
    chk("zw_awvalid_c1", M_AXI_AWVALID, 1'b1);
    chk("zw_wvalid_c1", M_AXI_WVALID, 1'b1);
    chk("zw_awaddr_c1", M_AXI_AWADDR, 32'h0);
    chk("zw_wdata_c1", M_AXI_WDATA, 32'h0000A5A5);
    chk("zw_wstrb_c1", M_AXI_WSTRB, 4'hF);
    step();
    chk("zw_bready_c2", M_AXI_BREADY, 1'b1);
    step();
    chk("zw_widle_c3", cmd_widle, 1'b1);
    chk("zw_wresp_c3", cmd_wresp, 2'b00);
    chk("zw_aw_count", n_aw - aw0, 1);
    $display("txn zero-wait write done: wresp=%0d", cmd_wresp);

    // WREADY four cycles ahead of AWREADY.
    set_lat(4, 0, 0, 0, 0); dir_bresp = 2'b10;
    aw0 = n_aw; w0 = n_w; b0 = n_b;
    cmd_waddr = 32'h8; cmd_wdata = 32'hCAFEF00D; cmd_write = 1;
    step();
    step();
    chk("wfirst_wvalid_dropped", M_AXI_WVALID, 1'b0);
    chk("wfirst_awvalid_held", M_AXI_AWVALID, 1'b1);
    chk("wfirst_bready_low", M_AXI_BREADY, 1'b0);
    wait_widle(30, "wfirst_timeout");
    chk("wfirst_aw_count", n_aw - aw0, 1);
    chk("wfirst_w_count", n_w - w0, 1);
    chk("wfirst_b_count", n_b - b0, 1);
    chk("wfirst_wresp", cmd_wresp, 2'b10);
    $display("txn W-before-AW write done: wresp=%0d", cmd_wresp);

    // Read with a 5-cycle RVALID delay.
    set_lat(0, 0, 0, 0, 5); dir_rdata = 32'h12345678; dir_rresp = 2'd3;
    ar0 = n_ar; r0 = n_r;
    cmd_raddr = 32'h4; cmd_read = 1;
    step();
    step();
    step();
    chk("rdelay_rready_wait", M_AXI_RREADY, 1'b1);
    wait_ridle(30, "rdelay_timeout");
    chk("rdelay_rdata", cmd_rdata, 32'h12345678);
    chk("rdelay_rresp", cmd_rresp, 2'd3);
    chk("rdelay_counts", {n_ar - ar0, n_r - r0}, {32'd1, 32'd1});
    $display("txn delayed read done: rdata=%08h rresp=%0d", cmd_rdata, cmd_rresp);

    // Second write pulsed during the response phase is dropped.
    set_lat(0, 0, 3, 0, 0); dir_bresp = 2'b01;
    aw0 = n_aw;
    cmd_waddr = 32'h10; cmd_wdata = 32'h11111111; cmd_write = 1;
    step();
    step();
    chk("drop_in_resp", M_AXI_BREADY, 1'b1);
    cmd_waddr = 32'h20; cmd_wdata = 32'h22222222; cmd_write = 1;
    step();
    wait_widle(30, "drop_timeout");
    repeat (3) step();
    chk("drop_aw_count", n_aw - aw0, 1);
    chk("drop_awaddr", last_awaddr, 32'h10);
    chk("drop_wdata", last_wdata, 32'h11111111);
    chk("drop_wresp", cmd_wresp, 2'b01);
    $display("txn dropped second write: aw=%0d wdata=%08h", n_aw - aw0, last_wdata);

    // Concurrent write and read, AWREADY held off 10 cycles.
    set_lat(10, 0, 0, 0, 0); dir_rdata = 32'hDEADBEEF; dir_rresp = 2'd0; dir_bresp = 2'd0;
    cmd_waddr = 32'h30; cmd_wdata = 32'h33333333; cmd_write = 1;
    cmd_raddr = 32'h34; cmd_read = 1;
    step();
    wait_ridle(20, "conc_read_timeout");
    chk("conc_write_busy", cmd_widle, 1'b0);
    chk("conc_rdata", cmd_rdata, 32'hDEADBEEF);
    wait_widle(30, "conc_write_timeout");
    chk("conc_both_idle", {cmd_widle, cmd_ridle}, 2'b11);
    $display("txn concurrent write/read done: rdata=%08h", cmd_rdata);

    // Reset during a stalled AW phase.
    set_lat(100, 100, 0, 0, 0);
    cmd_waddr = 32'h40; cmd_wdata = 32'h44444444; cmd_write = 1;
    step();
    step();
    chk("rst_pre_awvalid", M_AXI_AWVALID, 1'b1);
    resetn = 1'b0;
    step();
    chk("rst_valids", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}, 5'b0);
    chk("rst_idles", {cmd_widle, cmd_ridle}, 2'b11);
    chk("rst_wresp", cmd_wresp, 2'b00);
    chk("rst_addr_data", {M_AXI_AWADDR, M_AXI_WDATA}, 64'h0);
    resetn = 1'b1;
    set_lat(0, 0, 0, 0, 0);
    step();
    $display("txn reset mid-write: widle=%0d ridle=%0d", cmd_widle, cmd_ridle);

    // Randomized commands and slave timing.
    rand_mode = 1;
    aw0 = n_aw; w0 = n_w; b0 = n_b; ar0 = n_ar; r0 = n_r;
    m_wacc = 0; m_racc = 0;
    for (int i = 0; i < 3000; i++) begin
      cmd_write = ($urandom_range(0, 3) == 0);
      cmd_waddr = $urandom & 32'hFFFF_FFFC;
      cmd_wdata = $urandom;
      cmd_read  = ($urandom_range(0, 3) == 0);
      cmd_raddr = $urandom & 32'hFFFF_FFFC;
      step();
    end
    wait_widle(50, "rand_wdrain_timeout");
    wait_ridle(50, "rand_rdrain_timeout");
    chk("rand_aw_count", n_aw - aw0, m_wacc);
    chk("rand_w_count", n_w - w0, m_wacc);
    chk("rand_b_count", n_b - b0, m_wacc);
    chk("rand_ar_count", n_ar - ar0, m_racc);
    chk("rand_r_count", n_r - r0, m_racc);
    $display("txn random phase: writes=%0d reads=%0d", m_wacc, m_racc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
